// File: rtl/noc_inject_arbiter.sv
// Packet round-robin arbiter for the NoC local injection port; zero-latency datapath.
// Backpressure: out_ready gates every req_ready; a granted packet holds the port until its tail.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = `Noc_Data_Width,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    noc_clk,
  input  logic                    noc_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_flit,
  input  logic [N_REQ-1:0]        req_is_header,
  input  logic [N_REQ-1:0]        req_is_tail,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_flit,
  output logic                    out_is_header,
  output logic                    out_is_tail,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  output logic [15:0]             pkt_count,
  output logic                    proto_err
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d, owner_d;
  logic             err_d, pkt_done;
  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] scan_sel, scan_idx, sel;
  logic             scan_hit, grant_active, sel_valid, xfer;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == N_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Round-robin scan over header candidates, starting at rr_ptr.
  assign cand = req_valid & req_is_header;

  always_comb begin
    scan_sel = rr_ptr;
    scan_hit = 1'b0;
    scan_idx = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!scan_hit && cand[scan_idx]) begin
        scan_hit = 1'b1;
        scan_sel = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      owner     <= owner_d;
      proto_err <= err_d;
      if (pkt_done) pkt_count <= pkt_count + 16'd1;
    end
  end

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr;
    owner_d  = owner;
    err_d    = proto_err;
    pkt_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          owner_d = sel;
          if (out_is_tail) begin
            rr_ptr_d = next_idx(sel);
            pkt_done = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (req_valid[owner] && req_is_header[owner] && req_is_tail[owner]) err_d = 1'b1;
        if (xfer) begin
          // A stray header inside a packet is forwarded but never ends or restarts the lock.
          if (out_is_header) begin
            err_d = 1'b1;
          end else if (out_is_tail) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_idx(owner);
            pkt_done = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    sel          = scan_sel;
    grant_active = scan_hit;
    sel_valid    = scan_hit;
    if (state_q == ST_LOCKED) begin
      sel          = owner;
      grant_active = 1'b1;
      sel_valid    = req_valid[owner];
    end
    out_valid     = 1'b0;
    out_flit      = '0;
    out_is_header = 1'b0;
    out_is_tail   = 1'b0;
    req_ready     = '0;
    if (noc_rst_n) begin
      out_valid     = sel_valid;
      out_flit      = req_flit[int'(sel)*DATA_W +: DATA_W];
      out_is_header = req_is_header[sel];
      out_is_tail   = req_is_tail[sel];
      if (grant_active && out_ready) req_ready[sel] = 1'b1;
    end
  end

  assign busy = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter with a packet-level reference model checked every cycle.
module tb_noc_inject_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  typedef struct packed {logic [DW-1:0] d; logic h; logic t;} fl_t;
  typedef struct {int cyc; logic [3:0] rdy; logic [DW-1:0] d; logic h;} lg_t;

  logic            clk, rst_n;
  logic [NR-1:0]   req_valid, req_ready, req_is_header, req_is_tail;
  logic [NR*DW-1:0] req_flit;
  logic            out_valid, out_ready, out_is_header, out_is_tail;
  logic [DW-1:0]   out_flit;
  logic            busy, proto_err;
  logic [1:0]      owner;
  logic [15:0]     pkt_count;

  noc_inject_arbiter #(.N_REQ(NR), .DATA_W(DW)) dut (
    .noc_clk(clk), .noc_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .req_is_header(req_is_header), .req_is_tail(req_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .busy(busy), .owner(owner), .pkt_count(pkt_count), .proto_err(proto_err)
  );

  fl_t  q[NR][$];
  bit   rq[$];
  lg_t  xlog[$];
  int   n_checks = 0, n_fail = 0, cyc = 0, busy_cnt = 0;

  // Packet-level model: lock flag, owner, priority pointer, completed packets, error flag.
  bit   m_locked, m_err;
  int   m_owner, m_ptr, m_pkts;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input driver: advances each requester's flit queue after an accepted transfer.
  initial begin : drv
    logic [NR-1:0] took;
    req_valid = '0; req_is_header = '0; req_is_tail = '0; req_flit = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      took = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (took[i] && q[i].size() > 0) void'(q[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_flit[i*DW +: DW] = q[i][0].d;
          req_is_header[i] = q[i][0].h;
          req_is_tail[i] = q[i][0].t;
        end else begin
          req_valid[i] = 1'b0;
          req_flit[i*DW +: DW] = '0;
          req_is_header[i] = 1'b0;
          req_is_tail[i] = 1'b0;
        end
      end
      if (rq.size() > 0) out_ready = rq.pop_front();
      else out_ready = 1'b1;
    end
  end

  // Per-cycle compare against the model, then advance the model to the next edge.
  initial begin : cmp
    int s, idx;
    bit found, grant, ev, xf, hs, ts;
    logic [NR-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_out_flit", 64'(out_flit), 64'd0);
        check("rst_markers", 64'({out_is_header, out_is_tail}), 64'd0);
        check("rst_state", 64'({busy, proto_err, owner, pkt_count}), 64'd0);
        m_locked = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_pkts = 0;
      end else begin
        if (!m_locked) begin
          found = 0; s = m_ptr;
          for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!found && req_valid[idx] && req_is_header[idx]) begin
              found = 1; s = idx;
            end
          end
          grant = found; ev = found;
        end else begin
          s = m_owner; grant = 1; ev = req_valid[m_owner];
        end
        exp_rdy = (grant && out_ready) ? (NR'(1) << s) : '0;
        check("out_valid", 64'(out_valid), 64'(ev));
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(m_locked));
        check("owner", 64'(owner), 64'(m_owner));
        check("pkt_count", 64'(pkt_count), 64'(m_pkts));
        check("proto_err", 64'(proto_err), 64'(m_err));
        if (ev) begin
          check("out_flit", 64'(out_flit), 64'(req_flit[s*DW +: DW]));
          check("out_is_header", 64'(out_is_header), 64'(req_is_header[s]));
          check("out_is_tail", 64'(out_is_tail), 64'(req_is_tail[s]));
        end
        if (busy) busy_cnt++;
        if (out_valid && out_ready)
          xlog.push_back('{cyc: cyc, rdy: req_ready, d: out_flit, h: out_is_header});

        xf = ev && out_ready;
        hs = req_is_header[s];
        ts = req_is_tail[s];
        if (m_locked && ((xf && hs) ||
            (req_valid[m_owner] && req_is_header[m_owner] && req_is_tail[m_owner])))
          m_err = 1;
        if (xf) begin
          if (!m_locked) begin
            m_owner = s;
            if (ts) begin
              m_ptr = (s + 1) % NR;
              m_pkts = (m_pkts + 1) % 65536;
            end else begin
              m_locked = 1;
            end
          end else if (ts && !hs) begin
            m_locked = 0;
            m_ptr = (m_owner + 1) % NR;
            m_pkts = (m_pkts + 1) % 65536;
          end
        end
      end
    end
  end

  task automatic push_flit(input int r, input logic [DW-1:0] d, input logic h, input logic t);
    q[r].push_back('{d: d, h: h, t: t});
  endtask

  task automatic push_pkt(input int r, input int n, input logic [DW-1:0] base);
    for (int j = 0; j < n; j++)
      push_flit(r, base + DW'(j), (j == 0), (j == n - 1));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (q[i].size() > 0) return 0;
    return rq.size() == 0;
  endfunction

  function automatic logic [63:0] ready_seq(input bit hdr_only);
    logic [63:0] v = 0;
    foreach (xlog[j]) if (!hdr_only || xlog[j].h) v = (v << 4) | 64'(xlog[j].rdy);
    return v;
  endfunction

  function automatic int span();
    if (xlog.size() == 0) return -1;
    return xlog[xlog.size()-1].cyc - xlog[0].cyc;
  endfunction

  task automatic clear_logs();
    xlog.delete();
    busy_cnt = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (!all_empty() && k < 100) begin
      @(negedge clk); #2;
      k++;
    end
    check("drain_timeout", 64'(k >= 100), 64'd0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) q[i].delete();
    rq.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin : main
    rst_n = 1'b0;
    do_reset();
    check("init_pkt_count", 64'(pkt_count), 64'd0);
    check("init_owner_busy_err", 64'({owner, busy, proto_err}), 64'd0);

    // Lone requester 2 sends H,D,T.
    push_pkt(2, 3, 32'h200);
    drain();
    check("t1_ready_seq", ready_seq(0), 64'h444);
    check("t1_span", 64'(span()), 64'd2);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd2);
    check("t1_pkt_count", 64'(pkt_count), 64'd1);
    // rr pointer now at 3: req 3 beats req 0.
    clear_logs();
    push_pkt(0, 1, 32'h010);
    push_pkt(3, 1, 32'h310);
    drain();
    check("t1b_hdr_order", ready_seq(1), 64'h81);
    check("t1b_pkt_count", 64'(pkt_count), 64'd3);

    // Three requesters competing with 3-flit packets.
    do_reset();
    push_pkt(0, 3, 32'h000);
    push_pkt(0, 3, 32'h010);
    push_pkt(1, 3, 32'h100);
    push_pkt(3, 3, 32'h300);
    drain();
    check("t2_hdr_order", ready_seq(1), 64'h1281);
    check("t2_nxfer", 64'(xlog.size()), 64'd12);
    check("t2_span", 64'(span()), 64'd11);
    check("t2_pkt_count", 64'(pkt_count), 64'd4);

    // Req 0 header arrives while req 1 is mid-packet.
    do_reset();
    push_pkt(1, 3, 32'h100);
    @(negedge clk); #2;
    push_pkt(0, 3, 32'h000);
    drain();
    check("t3_ready_seq", ready_seq(0), 64'h222111);
    check("t3_span", 64'(span()), 64'd5);

    // Single-flit packets back to back.
    do_reset();
    push_pkt(3, 1, 32'h300);
    @(negedge clk); #2;
    push_pkt(0, 1, 32'h000);
    drain();
    check("t4_hdr_order", ready_seq(1), 64'h81);
    check("t4_span", 64'(span()), 64'd1);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd0);
    check("t4_pkt_count", 64'(pkt_count), 64'd2);

    // out_ready toggling during a 4-flit packet.
    do_reset();
    push_pkt(1, 4, 32'h100);
    for (int j = 0; j < 8; j++) rq.push_back(j % 2 == 0);
    drain();
    check("t5_nxfer", 64'(xlog.size()), 64'd4);
    for (int j = 0; j < 4; j++)
      if (j < xlog.size()) check("t5_flit_order", 64'(xlog[j].d), 64'h100 + 64'(j));
    check("t5_span", 64'(span()), 64'd6);
    check("t5_busy_cycles", 64'(busy_cnt), 64'd6);

    // Second header inside a packet, then reset mid-packet.
    do_reset();
    push_flit(2, 32'h200, 1'b1, 1'b0);
    push_flit(2, 32'h201, 1'b0, 1'b0);
    push_flit(2, 32'h202, 1'b1, 1'b0);
    push_flit(2, 32'h203, 1'b0, 1'b1);
    drain();
    check("t6_proto_err", 64'(proto_err), 64'd1);
    check("t6_nxfer", 64'(xlog.size()), 64'd4);
    check("t6_pkt_count", 64'(pkt_count), 64'd1);
    push_flit(2, 32'h210, 1'b1, 1'b0);
    push_flit(2, 32'h211, 1'b0, 1'b0);
    drain();
    check("t6_busy_mid", 64'(busy), 64'd1);
    check("t6_err_sticky", 64'(proto_err), 64'd1);
    do_reset();
    check("t6_after_rst", 64'({busy, proto_err, pkt_count}), 64'd0);
    push_pkt(2, 1, 32'h220);
    push_pkt(0, 1, 32'h020);
    drain();
    check("t6_hdr_order", ready_seq(1), 64'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
